// File: rtl/systolic_ctrl.sv
// Systolic array pass controller: issues skewed operand-load pulses, then
// N result-row write strobes, then a one-cycle done pulse.
// Optional feature: define SYSTOLIC_CTRL_STALL_EN to add a 'stall' input
// that freezes a pass in progress.
module systolic_ctrl #(
  parameter int unsigned N        = 2,
  parameter int unsigned M        = 2,
  parameter int unsigned K_W      = 8,
  parameter int unsigned LOAD_GAP = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
`ifdef SYSTOLIC_CTRL_STALL_EN
  input  logic                                 stall,
`endif
  input  logic                                 start,
  input  logic [K_W-1:0]                       k_len,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 load,
  output logic [N-1:0]                         A_start_en,
  output logic [M-1:0]                         B_start_en,
  output logic                                 C_write_en,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] c_row
);

  // Headroom of 8 bits covers N+M-1 <= 127 added to a full-scale k_len.
  localparam int unsigned CntW = K_W + 8;
  localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0]      GapLast = 4'((LOAD_GAP > 0) ? LOAD_GAP - 1 : 0);
  localparam logic [RowW-1:0] RowLast = RowW'(N - 1);
  localparam logic [CntW-1:0] Skew    = CntW'(N + M - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StGap, StWrite, StDone} state_e;

`ifndef SYSTOLIC_CTRL_STALL_EN
  logic stall;
  assign stall = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [K_W-1:0]  kq_q, kq_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      gap_q, gap_d;
  logic [RowW-1:0] row_q, row_d;
  logic [N-1:0]    a_en_q, a_en_d;
  logic [M-1:0]    b_en_q, b_en_d;

  logic [CntW-1:0] num_pulses;
  logic            feed_bit;
  logic            hold;

  assign num_pulses = CntW'(kq_q) + Skew;
  // Real operand beats first, then zeros to flush the skew out of the array.
  assign feed_bit   = (cnt_q < CntW'(kq_q));
  // Stall only freezes an active pass; IDLE keeps accepting start.
  assign hold       = stall && (state_q != StIdle);

  // Next-state, counter and shift-register update.
  always_comb begin
    state_d = state_q;
    kq_d    = kq_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    row_d   = row_q;
    a_en_d  = a_en_q;
    b_en_d  = b_en_q;
    if (!hold) begin
      case (state_q)
        StIdle: begin
          if (start) begin
            kq_d    = k_len;
            cnt_d   = '0;
            gap_d   = '0;
            row_d   = '0;
            a_en_d  = '0;
            b_en_d  = '0;
            state_d = (k_len == '0) ? StDone : StLoad;
          end
        end
        StLoad: begin
          a_en_d = {a_en_q[N-2:0], feed_bit};
          b_en_d = {b_en_q[M-2:0], feed_bit};
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q + CntW'(1) == num_pulses) begin
            state_d = StWrite;
            row_d   = '0;
          end else if (LOAD_GAP == 0) begin
            state_d = StLoad;
          end else begin
            state_d = StGap;
            gap_d   = '0;
          end
        end
        StGap: begin
          if (gap_q == GapLast) begin
            state_d = StLoad;
          end else begin
            gap_d = gap_q + 4'd1;
          end
        end
        StWrite: begin
          if (row_q == RowLast) begin
            state_d = StDone;
          end else begin
            row_d = row_q + RowW'(1);
          end
        end
        StDone: begin
          state_d = StIdle;
          row_d   = '0;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kq_q    <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      row_q   <= '0;
      a_en_q  <= '0;
      b_en_q  <= '0;
    end else begin
      state_q <= state_d;
      kq_q    <= kq_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      row_q   <= row_d;
      a_en_q  <= a_en_d;
      b_en_q  <= b_en_d;
    end
  end

  // Strobes decode from the state register and are masked while stalled.
  always_comb begin
    busy       = (state_q != StIdle);
    load       = (state_q == StLoad) && !stall;
    C_write_en = (state_q == StWrite) && !stall;
    done       = (state_q == StDone) && !stall;
    A_start_en = a_en_q;
    B_start_en = b_en_q;
    c_row      = row_q;
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl: two instances (N=M=2 gap 1, N=4 M=2 gap 0).
module tb_systolic_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic stall_a;
  logic start_a, start_b;
  logic [7:0] k_a, k_b;

  logic busy_a, done_a, load_a, cw_a;
  logic [1:0] aen_a, ben_a;
  logic [0:0] row_a;
  logic busy_b, done_b, load_b, cw_b;
  logic [3:0] aen_b;
  logic [1:0] ben_b;
  logic [1:0] row_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(2), .M(2), .K_W(8), .LOAD_GAP(1)) dut_a (
    .clk        (clk),
    .rst        (rst),
`ifdef SYSTOLIC_CTRL_STALL_EN
    .stall      (stall_a),
`endif
    .start      (start_a),
    .k_len      (k_a),
    .busy       (busy_a),
    .done       (done_a),
    .load       (load_a),
    .A_start_en (aen_a),
    .B_start_en (ben_a),
    .C_write_en (cw_a),
    .c_row      (row_a)
  );

  systolic_ctrl #(.N(4), .M(2), .K_W(8), .LOAD_GAP(0)) dut_b (
    .clk        (clk),
    .rst        (rst),
`ifdef SYSTOLIC_CTRL_STALL_EN
    .stall      (1'b0),
`endif
    .start      (start_b),
    .k_len      (k_b),
    .busy       (busy_b),
    .done       (done_b),
    .load       (load_b),
    .A_start_en (aen_b),
    .B_start_en (ben_b),
    .C_write_en (cw_b),
    .c_row      (row_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_checks++;
    if ({busy_a, done_a, load_a, cw_a, aen_a, ben_a, row_a} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_a: got %b required 0",
               {busy_a, done_a, load_a, cw_a, aen_a, ben_a, row_a});
    end
    n_checks++;
    if ({busy_b, done_b, load_b, cw_b, aen_b, ben_b, row_b} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_b: got %b required 0",
               {busy_b, done_b, load_b, cw_b, aen_b, ben_b, row_b});
    end
    rst = 1'b0;
    step();
  endtask

  // N=M=2, LOAD_GAP=1, k_len=3: P=6 pulses at odd cycles, done at t+14.
  task automatic test_pass_gap();
    logic [1:0] a_tab [6] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00};
    logic [1:0] exp_a;
    logic exp_load, exp_cw, exp_done, exp_busy;
    int loads = 0;
    start_a = 1'b1;
    k_a     = 8'd3;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      exp_load = (c <= 11) && (c % 2 == 1);
      exp_cw   = (c == 12) || (c == 13);
      exp_done = (c == 14);
      exp_busy = (c <= 14);
      exp_a    = (c >= 2 && c <= 13) ? a_tab[(c - 2) / 2] : 2'b00;
      if (load_a) loads++;
      n_checks++;
      if ({load_a, cw_a, done_a, busy_a} !== {exp_load, exp_cw, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL gap_strobes c=%0d: got %b required %b", c,
                 {load_a, cw_a, done_a, busy_a}, {exp_load, exp_cw, exp_done, exp_busy});
      end
      n_checks++;
      if (aen_a !== exp_a || ben_a !== exp_a) begin
        n_fail++;
        $display("FAIL gap_start_en c=%0d: got A=%b B=%b required %b", c, aen_a, ben_a, exp_a);
      end
      if (exp_cw) begin
        n_checks++;
        if (row_a !== 1'(c - 12)) begin
          n_fail++;
          $display("FAIL gap_c_row c=%0d: got %0d required %0d", c, row_a, c - 12);
        end
      end
      step();
    end
    n_checks++;
    if (loads != 6) begin
      n_fail++;
      $display("FAIL gap_load_count: got %0d required 6", loads);
    end
  endtask

  // N=4, M=2, LOAD_GAP=0, k_len=1: 6 consecutive pulses, done at t+11.
  task automatic test_pass_nogap();
    logic [3:0] a_tab [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000};
    logic [1:0] b_tab [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [3:0] exp_a;
    logic [1:0] exp_b;
    logic exp_load, exp_cw, exp_done, exp_busy;
    start_b = 1'b1;
    k_b     = 8'd1;
    step();
    start_b = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      exp_load = (c <= 6);
      exp_cw   = (c >= 7) && (c <= 10);
      exp_done = (c == 11);
      exp_busy = (c <= 11);
      exp_a    = (c >= 2 && c <= 7) ? a_tab[c - 2] : 4'b0000;
      exp_b    = (c >= 2 && c <= 7) ? b_tab[c - 2] : 2'b00;
      n_checks++;
      if ({load_b, cw_b, done_b, busy_b} !== {exp_load, exp_cw, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL nogap_strobes c=%0d: got %b required %b", c,
                 {load_b, cw_b, done_b, busy_b}, {exp_load, exp_cw, exp_done, exp_busy});
      end
      n_checks++;
      if (aen_b !== exp_a || ben_b !== exp_b) begin
        n_fail++;
        $display("FAIL nogap_start_en c=%0d: got A=%b B=%b required A=%b B=%b", c,
                 aen_b, ben_b, exp_a, exp_b);
      end
      if (exp_cw) begin
        n_checks++;
        if (row_b !== 2'(c - 7)) begin
          n_fail++;
          $display("FAIL nogap_c_row c=%0d: got %0d required %0d", c, row_b, c - 7);
        end
      end
      step();
    end
  endtask

  // k_len=0: done and busy at t+1, idle at t+2.
  task automatic test_zero_k();
    start_a = 1'b1;
    k_a     = 8'd0;
    step();
    start_a = 1'b0;
    n_checks++;
    if ({done_a, busy_a, load_a, cw_a} !== 4'b1100) begin
      n_fail++;
      $display("FAIL zero_k_t1: got %b required 1100", {done_a, busy_a, load_a, cw_a});
    end
    step();
    n_checks++;
    if ({done_a, busy_a, load_a, cw_a} !== 4'b0000) begin
      n_fail++;
      $display("FAIL zero_k_t2: got %b required 0000", {done_a, busy_a, load_a, cw_a});
    end
  endtask

  // start held through a pass plus one cycle: two passes, done at 14 and 29.
  task automatic test_back_to_back();
    int dones = 0;
    int loads = 0;
    k_a = 8'd3;
    for (int c = 0; c <= 40; c++) begin
      start_a = (c <= 15);
      if (c >= 1) begin
        if (done_a) dones++;
        if (load_a) loads++;
        n_checks++;
        if (done_a !== ((c == 14) || (c == 29))) begin
          n_fail++;
          $display("FAIL b2b_done c=%0d: got %b required %b", c, done_a,
                   (c == 14) || (c == 29));
        end
        n_checks++;
        if (busy_a !== (c != 15 && c <= 29)) begin
          n_fail++;
          $display("FAIL b2b_busy c=%0d: got %b required %b", c, busy_a,
                   (c != 15 && c <= 29));
        end
      end
      step();
    end
    start_a = 1'b0;
    n_checks++;
    if (dones != 2 || loads != 12) begin
      n_fail++;
      $display("FAIL b2b_counts: got dones=%0d loads=%0d required 2 and 12", dones, loads);
    end
  endtask

  // Reset during WRITE aborts the pass; a later start runs cleanly.
  task automatic test_reset_mid();
    int dones = 0;
    int loads = 0;
    start_a = 1'b1;
    k_a     = 8'd3;
    step();
    start_a = 1'b0;
    for (int c = 1; c < 12; c++) step();
    n_checks++;
    if (cw_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_in_write: got C_write_en=%b required 1", cw_a);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if ({busy_a, done_a, load_a, cw_a, aen_a, ben_a, row_a} !== 9'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b required 0",
               {busy_a, done_a, load_a, cw_a, aen_a, ben_a, row_a});
    end
    for (int c = 0; c < 20; c++) begin
      if (done_a || busy_a) dones++;
      step();
    end
    n_checks++;
    if (dones != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %0d busy/done cycles required 0", dones);
    end
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (load_a) loads++;
      if (c == 14) begin
        n_checks++;
        if (done_a !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_clean_done: got %b required 1", done_a);
        end
      end
      step();
    end
    n_checks++;
    if (loads != 6) begin
      n_fail++;
      $display("FAIL rstmid_clean_loads: got %0d required 6", loads);
    end
  endtask

`ifdef SYSTOLIC_CTRL_STALL_EN
  // Stall for 3 cycles in GAP: everything after shifts by 3, done at t+17.
  task automatic test_stall();
    logic exp_load;
    int loads = 0;
    start_a = 1'b1;
    k_a     = 8'd3;
    step();
    start_a = 1'b0;
    for (int c = 1; c <= 19; c++) begin
      stall_a  = (c >= 2) && (c <= 4);
      #1;
      exp_load = (c == 1) || (c == 6) || (c == 8) || (c == 10) || (c == 12) || (c == 14);
      if (load_a) loads++;
      n_checks++;
      if ({load_a, cw_a, done_a} !== {exp_load, (c == 15 || c == 16), (c == 17)}) begin
        n_fail++;
        $display("FAIL stall_strobes c=%0d: got %b required %b", c,
                 {load_a, cw_a, done_a}, {exp_load, (c == 15 || c == 16), (c == 17)});
      end
      step();
    end
    stall_a = 1'b0;
    n_checks++;
    if (loads != 6) begin
      n_fail++;
      $display("FAIL stall_load_count: got %0d required 6", loads);
    end
  endtask
`endif

  initial begin
    rst     = 1'b1;
    stall_a = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    k_a     = '0;
    k_b     = '0;
    test_reset();
    test_pass_gap();
    test_pass_nogap();
    test_zero_k();
    step();
    test_back_to_back();
    test_reset_mid();
`ifdef SYSTOLIC_CTRL_STALL_EN
    step();
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Mutual exclusion of load, write strobe and done on every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      n_checks++;
      if ((32'(load_a) + 32'(cw_a) + 32'(done_a)) > 1 ||
          (32'(load_b) + 32'(cw_b) + 32'(done_b)) > 1) begin
        n_fail++;
        $display("FAIL mutex: got a=%b%b%b b=%b%b%b required at most one set",
                 load_a, cw_a, done_a, load_b, cw_b, done_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation ran past 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
